output_wrapper_sr: RTL and testbench

// - Serialises the six BCD time digits (HH:MM:SS) from the time register into a chain of
//   six 8-bit 7-segment shift registers (74HC595-style).
// - Drives serial data, shift clock and latch; blanks all segments when en is low.
// - Sits between time_register (digit source) and the chip pins; clocked by the divider's sr clock.

---
 rtl/output_wrapper_sr.sv | 135 +++++++++++++
 tb/tb_output_wrapper_sr.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/output_wrapper_sr.sv
// Serialises six BCD time digits into a chain of six 74HC595-style 7-segment shift registers.
// Optional macro LEADING_ZERO_BLANK_EN: a zero in hours_msd is shown blank instead of "0".
module output_wrapper_sr (
  input  logic       sr_clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] hours_msd,
  input  logic [3:0] hours_lsd,
  input  logic [3:0] minutes_msd,
  input  logic [3:0] minutes_lsd,
  input  logic [3:0] seconds_msd,
  input  logic [3:0] seconds_lsd,
  output logic       serial_out,
  output logic       latch_out,
  output logic       clk_out
);

  // state    | meaning
  // ST_LOAD  | capture digits (or a blank frame) into the 48-bit shift register
  // ST_SHIFT | two cycles per bit: phase0 present data, phase1 raise clk_out
  // ST_LATCH | two-cycle latch_out pulse transferring the frame to the displays
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t      state, nxt_state;
  logic [47:0] shift_reg, nxt_shift_reg;
  logic [5:0]  bit_cnt, nxt_bit_cnt;
  logic        phase, nxt_phase;
  logic        nxt_serial, nxt_latch, nxt_clk;
  logic [7:0]  byte0;
  logic [47:0] frame;

  // Segment order {a,b,c,d,e,f,g,dp}; non-decimal codes blank the digit.
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  assign byte0 = (hours_msd == 4'd0) ? 8'h00 : seg_encode(hours_msd);
`else
  assign byte0 = seg_encode(hours_msd);
`endif

  assign frame = {byte0, seg_encode(hours_lsd), seg_encode(minutes_msd),
                  seg_encode(minutes_lsd), seg_encode(seconds_msd), seg_encode(seconds_lsd)};

  // Outputs are registered from next-state values so the pins never glitch on state decode.
  always_comb begin
    nxt_state     = state;
    nxt_shift_reg = shift_reg;
    nxt_bit_cnt   = bit_cnt;
    nxt_phase     = phase;
    nxt_serial    = 1'b0;
    nxt_latch     = 1'b0;
    nxt_clk       = 1'b0;
    case (state)
      ST_LOAD: begin
        nxt_shift_reg = en ? frame : 48'h0;
        nxt_state     = ST_SHIFT;
        nxt_phase     = 1'b0;
        nxt_bit_cnt   = 6'd0;
        nxt_serial    = nxt_shift_reg[47];
      end
      ST_SHIFT: begin
        if (!phase) begin
          nxt_phase  = 1'b1;
          nxt_clk    = 1'b1;
          nxt_serial = shift_reg[47];
        end else begin
          nxt_phase     = 1'b0;
          nxt_shift_reg = {shift_reg[46:0], 1'b0};
          if (bit_cnt == 6'd47) begin
            nxt_state   = ST_LATCH;
            nxt_bit_cnt = 6'd0;
            nxt_latch   = 1'b1;
          end else begin
            nxt_bit_cnt = bit_cnt + 6'd1;
            nxt_serial  = shift_reg[46];
          end
        end
      end
      ST_LATCH: begin
        if (!phase) begin
          nxt_phase = 1'b1;
          nxt_latch = 1'b1;
        end else begin
          nxt_phase = 1'b0;
          nxt_state = ST_LOAD;
        end
      end
      default: begin
        nxt_state = ST_LOAD;
        nxt_phase = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sr_clk) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      shift_reg  <= 48'h0;
      bit_cnt    <= 6'd0;
      phase      <= 1'b0;
      serial_out <= 1'b0;
      latch_out  <= 1'b0;
      clk_out    <= 1'b0;
    end else begin
      state      <= nxt_state;
      shift_reg  <= nxt_shift_reg;
      bit_cnt    <= nxt_bit_cnt;
      phase      <= nxt_phase;
      serial_out <= nxt_serial;
      latch_out  <= nxt_latch;
      clk_out    <= nxt_clk;
    end
  end

endmodule

// File: tb/tb_output_wrapper_sr.sv
// Directed bench for output_wrapper_sr: captures whole frames on clk_out rises and checks
// frame contents, shift/latch cadence and data setup against hand-computed frames.
module tb_output_wrapper_sr;

  logic       sr_clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd;
  logic       serial_out, latch_out, clk_out;

  int n_pass  = 0;
  int n_total = 0;

  output_wrapper_sr dut (
    .sr_clk      (sr_clk),
    .rst_n       (rst_n),
    .en          (en),
    .hours_msd   (hours_msd),
    .hours_lsd   (hours_lsd),
    .minutes_msd (minutes_msd),
    .minutes_lsd (minutes_lsd),
    .seconds_msd (seconds_msd),
    .seconds_lsd (seconds_lsd),
    .serial_out  (serial_out),
    .latch_out   (latch_out),
    .clk_out     (clk_out)
  );

  always #5 sr_clk = ~sr_clk;

  task automatic set_digits(input logic [23:0] d, input logic e);
    {hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd} = d;
    en = e;
  endtask

  // Called at the falling edge of a LOAD cycle; returns at the falling edge of the next LOAD.
  task automatic run_frame(input string name, input logic [47:0] exp_bits,
                           input int chg_cyc, input logic [23:0] chg_dig, input logic chg_en);
    logic [47:0] got = 48'h0;
    int rises = 0, first_rise = -1, latch_first = -1, latch_n = 0, setup_bad = 0;
    logic prev_clk = 1'b0, prev_ser = 1'b0;
    for (int c = 0; c < 99; c++) begin
      if (c == chg_cyc) set_digits(chg_dig, chg_en);
      if (c == 0) begin
        n_total++;
        if ({serial_out, latch_out, clk_out} !== 3'b000)
          $display("FAIL %s load_idle: got %b want 000", name, {serial_out, latch_out, clk_out});
        else n_pass++;
      end
      if (clk_out === 1'b1 && prev_clk === 1'b0) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        got = {got[46:0], serial_out};
        if (serial_out !== prev_ser) setup_bad++;
      end
      if (latch_out === 1'b1) begin
        if (latch_first < 0) latch_first = c;
        latch_n++;
        if (clk_out !== 1'b0 || serial_out !== 1'b0) setup_bad++;
      end
      prev_clk = clk_out;
      prev_ser = serial_out;
      @(negedge sr_clk);
    end
    n_total++;
    if (got !== exp_bits) $display("FAIL %s bits: got %h want %h", name, got, exp_bits);
    else n_pass++;
    n_total++;
    if (rises != 48) $display("FAIL %s clk_rises: got %0d want 48", name, rises);
    else n_pass++;
    n_total++;
    if (first_rise != 2) $display("FAIL %s first_rise: got cycle %0d want 2", name, first_rise);
    else n_pass++;
    n_total++;
    if (latch_first != 97 || latch_n != 2)
      $display("FAIL %s latch: got start %0d len %0d want start 97 len 2", name, latch_first, latch_n);
    else n_pass++;
    n_total++;
    if (setup_bad != 0) $display("FAIL %s setup: got %0d violations want 0", name, setup_bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    set_digits(24'h123456, 1'b1);
    rst_n = 1'b0;
    @(posedge sr_clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge sr_clk);
      n_total++;
      if ({serial_out, latch_out, clk_out} !== 3'b000)
        $display("FAIL reset_outputs: got %b want 000", {serial_out, latch_out, clk_out});
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_display();
    set_digits(24'h123456, 1'b1);
    run_frame("display_a", 48'h60DAF266B6BE, -1, 24'h0, 1'b0);
    run_frame("display_b", 48'h60DAF266B6BE, -1, 24'h0, 1'b0);
  endtask

  task automatic test_blank();
    set_digits(24'h123456, 1'b0);
    run_frame("blank", 48'h0, -1, 24'h0, 1'b0);
  endtask

  task automatic test_mid_change();
    set_digits(24'h100000, 1'b1);
    run_frame("change_cur", 48'h60FCFCFCFCFC, 41, 24'h100001, 1'b1);
    run_frame("change_next", 48'h60FCFCFCFC60, -1, 24'h0, 1'b0);
  endtask

  task automatic test_hex_blank();
    set_digits(24'hA12345, 1'b1);
    run_frame("hex_blank", 48'h0060DAF266B6, -1, 24'h0, 1'b0);
  endtask

  task automatic test_leading_zero();
    set_digits(24'h095959, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    run_frame("leading_zero", 48'h00F6B6F6B6F6, -1, 24'h0, 1'b0);
`else
    run_frame("leading_zero", 48'hFCF6B6F6B6F6, -1, 24'h0, 1'b0);
`endif
  endtask

  task automatic test_en_toggle();
    set_digits(24'h123456, 1'b1);
    run_frame("en_toggle_cur", 48'h60DAF266B6BE, 21, 24'h123456, 1'b0);
    run_frame("en_toggle_next", 48'h0, -1, 24'h0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int latch_seen = 0;
    set_digits(24'h123456, 1'b1);
    for (int c = 0; c < 30; c++) @(negedge sr_clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sr_clk);
      if (latch_out !== 1'b0) latch_seen++;
      n_total++;
      if ({serial_out, latch_out, clk_out} !== 3'b000)
        $display("FAIL mid_reset_outputs: got %b want 000", {serial_out, latch_out, clk_out});
      else n_pass++;
    end
    n_total++;
    if (latch_seen != 0) $display("FAIL mid_reset_latch: got %0d pulses want 0", latch_seen);
    else n_pass++;
    rst_n = 1'b1;
    run_frame("after_reset", 48'h60DAF266B6BE, -1, 24'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_display();
    test_blank();
    test_mid_change();
    test_hex_blank();
    test_leading_zero();
    test_en_toggle();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
